// File: rtl/tbb_sched_pkg.sv
// Shared types and constants for the TBB1143 nibble-bus write scheduler.
package tbb_sched_pkg;

    localparam int unsigned NIB_W = 4;

    // A0 selects address latch (0) or data register (1) on the sound core
    localparam logic A0_ADDR = 1'b0;
    localparam logic A0_DATA = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAdrSetup,
        StAdrStrobe,
        StAdrHold,
        StDatSetup,
        StDatStrobe,
        StDatHold
    } sched_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tbb_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps modulo NREQ.
module tbb_rr_arbiter
    import tbb_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [2:0]      idx_o,
    output logic            any_o
);

    // Walk offsets from farthest to nearest so the nearest valid requester wins last
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_i[i] && (((32'(ptr_i) + k) % NREQ) == i)) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                    idx_o      = 3'(i);
                end
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/tbb_write_sched.sv
// Write scheduler for the TBB1143 nibble bus. Each accepted request becomes an address
// phase (A0=0) followed by a data phase (A0=1), each with setup / strobe / hold timing.
// Bus outputs are registered from the state register, so they trail the FSM by one cycle.
// Optional feature: define TBB_SCHED_ADDR_CACHE_EN to skip the address phase when the
// accepted address matches the last one written to the core.
module tbb_write_sched
    import tbb_sched_pkg::*;
#(
    parameter int unsigned NREQ          = 2,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NIB_W*NREQ-1:0] REQ_ADDR,
    input  logic [NIB_W*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]       REQ_READY,
    output logic [NIB_W-1:0]      BUS_D,
    output logic                  BUS_A0,
    output logic                  BUS_WR,
    output logic                  BUSY,
    output logic [2:0]            GRANT_ID
);

    localparam int unsigned MaxCyc = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    // Counters load N-1 on entry and the state exits when they reach zero
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);

    sched_state_e     state_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_dec;
    logic             cnt_done;
    logic [NIB_W-1:0] addr_q;
    logic [NIB_W-1:0] data_q;
    logic [2:0]       ptr_q;

    logic [NREQ-1:0]  arb_grant;
    logic [2:0]       arb_idx;
    logic             arb_any;
    logic             accept;
    logic             cache_hit;
    logic [NIB_W-1:0] sel_addr;
    logic [NIB_W-1:0] sel_data;

    tbb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (REQ_VALID),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign cnt_done = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CntW'(1);
    assign accept   = (state_q == StIdle) && arb_any;

    // READY is gated by reset so every output reads zero while RST is low
    always_comb begin
        REQ_READY = '0;
        if ((state_q == StIdle) && RST) begin
            REQ_READY = arb_grant;
        end
    end

    // Pick the winning requester's operands out of the packed input buses
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = REQ_ADDR[NIB_W*i +: NIB_W];
                sel_data = REQ_DATA[NIB_W*i +: NIB_W];
            end
        end
    end

`ifdef TBB_SCHED_ADDR_CACHE_EN
    logic [NIB_W-1:0] cache_addr_q;
    logic             cache_vld_q;

    assign cache_hit = cache_vld_q && (sel_addr == cache_addr_q);

    // Remember the address once its strobe and hold have completed on the bus
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cache_addr_q <= '0;
            cache_vld_q  <= 1'b0;
        end else if ((state_q == StAdrHold) && cnt_done) begin
            cache_addr_q <= addr_q;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Sequencer: timed state walk, operand capture at accept, bus pins registered from state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ptr_q    <= 3'(NREQ - 1);
            GRANT_ID <= '0;
            BUS_D    <= '0;
            BUS_A0   <= 1'b0;
            BUS_WR   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            BUSY <= (state_q != StIdle);

            // D and A0 only change in setup states, never while WR is high
            unique case (state_q)
                StAdrSetup, StAdrStrobe, StAdrHold: begin
                    BUS_A0 <= A0_ADDR;
                    BUS_D  <= addr_q;
                    BUS_WR <= (state_q == StAdrStrobe);
                end
                StDatSetup, StDatStrobe, StDatHold: begin
                    BUS_A0 <= A0_DATA;
                    BUS_D  <= data_q;
                    BUS_WR <= (state_q == StDatStrobe);
                end
                default: begin
                    BUS_WR <= 1'b0;
                end
            endcase

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q   <= sel_addr;
                        data_q   <= sel_data;
                        ptr_q    <= arb_idx;
                        GRANT_ID <= arb_idx;
                        cnt_q    <= SetupLoad;
                        state_q  <= cache_hit ? StDatSetup : StAdrSetup;
                    end
                end
                StAdrSetup: begin
                    if (cnt_done) begin
                        state_q <= StAdrStrobe;
                        cnt_q   <= StrobeLoad;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StAdrStrobe: begin
                    if (cnt_done) begin
                        state_q <= StAdrHold;
                        cnt_q   <= HoldLoad;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StAdrHold: begin
                    if (cnt_done) begin
                        state_q <= StDatSetup;
                        cnt_q   <= SetupLoad;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StDatSetup: begin
                    if (cnt_done) begin
                        state_q <= StDatStrobe;
                        cnt_q   <= StrobeLoad;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StDatStrobe: begin
                    if (cnt_done) begin
                        state_q <= StDatHold;
                        cnt_q   <= HoldLoad;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StDatHold: begin
                    if (cnt_done) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
